// File: rtl/forward_control_unit_if.sv
// Decode-side hazard inputs and Execute-side forwarding/stall outputs of the forwarding controller.
// The master drives the Decode and pipeline-control inputs; the slave (the controller) drives the selects, stall/bubble and counter.
interface forward_control_unit_if #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
);
  logic                   idValid;
  logic [REG_ADDR_W-1:0]  idRs1;
  logic [REG_ADDR_W-1:0]  idRs2;
  logic [REG_ADDR_W-1:0]  idRd;
  logic                   idRegWrite;
  logic                   idMemRead;
  logic                   exFlush;
  logic                   pipeHold;
  logic [1:0]             forwardSelect1;
  logic [1:0]             forwardSelect2;
  logic                   stallDecode;
  logic                   bubbleExecute;
  logic [STALL_CNT_W-1:0] stallCount;

  modport master (
    output idValid, idRs1, idRs2, idRd, idRegWrite, idMemRead, exFlush, pipeHold,
    input  forwardSelect1, forwardSelect2, stallDecode, bubbleExecute, stallCount
  );

  modport slave (
    input  idValid, idRs1, idRs2, idRd, idRegWrite, idMemRead, exFlush, pipeHold,
    output forwardSelect1, forwardSelect2, stallDecode, bubbleExecute, stallCount
  );
endinterface

// File: rtl/forward_control_unit.sv
// Forwarding select, load-use stall/bubble and stall-cycle counter for the 5-stage core.
// Zero-cycle combinational outputs from EX/MEM/WB metadata; pipeHold freezes all state including the counter.
module forward_control_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  forward_control_unit_if.slave bus
);

  typedef logic [REG_ADDR_W-1:0] regAddr_t;

  typedef struct packed {
    logic     valid;
    regAddr_t rs1;
    regAddr_t rs2;
    regAddr_t rd;
    logic     regWrite;
    logic     memRead;
  } exStage_t;

  typedef struct packed {
    logic     valid;
    regAddr_t rd;
    logic     regWrite;
  } wrStage_t;

  exStage_t               exStage;
  wrStage_t               memStage;
  wrStage_t               wbStage;
  logic [STALL_CNT_W-1:0] stallCnt;
  logic                   hazard;
  logic                   stallDecode;
  logic                   bubbleExecute;
  logic [1:0]             fwdSel1;
  logic [1:0]             fwdSel2;

  function automatic logic writesReg(input wrStage_t stage, input regAddr_t r);
    return stage.valid && stage.regWrite && (stage.rd == r) && (r != '0);
  endfunction

  // MEM is checked first: it holds the youngest producer of the register.
  function automatic logic [1:0] selectFor(input logic exValid, input wrStage_t memS,
                                           input wrStage_t wbS, input regAddr_t r);
    if (!exValid)           return 2'b00;
    if (writesReg(memS, r)) return 2'b01;
    if (writesReg(wbS, r))  return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    hazard = exStage.valid && exStage.memRead && exStage.regWrite && (exStage.rd != '0) &&
             bus.idValid && ((exStage.rd == bus.idRs1) || (exStage.rd == bus.idRs2));
    // A taken branch discards the Decode instruction, so it must not be held.
    stallDecode   = hazard && !bus.exFlush;
    bubbleExecute = hazard || bus.exFlush;
    fwdSel1       = selectFor(exStage.valid, memStage, wbStage, exStage.rs1);
    fwdSel2       = selectFor(exStage.valid, memStage, wbStage, exStage.rs2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exStage  <= '0;
      memStage <= '0;
      wbStage  <= '0;
      stallCnt <= '0;
    end else if (!bus.pipeHold) begin
      wbStage  <= memStage;
      memStage <= '{valid: exStage.valid, rd: exStage.rd, regWrite: exStage.regWrite};
      if (bubbleExecute || !bus.idValid) begin
        exStage <= '0;
      end else begin
        exStage <= '{valid: 1'b1, rs1: bus.idRs1, rs2: bus.idRs2, rd: bus.idRd,
                     regWrite: bus.idRegWrite, memRead: bus.idMemRead};
      end
      if (stallDecode && (stallCnt != '1)) begin
        stallCnt <= stallCnt + STALL_CNT_W'(1);
      end
    end
  end

  assign bus.forwardSelect1 = fwdSel1;
  assign bus.forwardSelect2 = fwdSel2;
  assign bus.stallDecode    = stallDecode;
  assign bus.bubbleExecute  = bubbleExecute;
  assign bus.stallCount     = stallCnt;

endmodule

// File: tb/tb_forward_control_unit.sv
// Bench for forward_control_unit: directed vector table, reset corners and randomized stream against an instruction-level model.
// A second instance with a 4-bit counter shares the stimulus so counter saturation is reachable in a short run.
module tb_forward_control_unit;

  localparam int RW = 5;
  localparam int CW = 16;
  localparam int SW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  forward_control_unit_if #(.REG_ADDR_W(RW), .STALL_CNT_W(CW)) bus ();
  forward_control_unit_if #(.REG_ADDR_W(RW), .STALL_CNT_W(SW)) busS ();

  forward_control_unit #(.REG_ADDR_W(RW), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  forward_control_unit #(.REG_ADDR_W(RW), .STALL_CNT_W(SW)) dutS (
    .clk(clk), .rst_n(rst_n), .bus(busS.slave)
  );

  assign busS.idValid    = bus.idValid;
  assign busS.idRs1      = bus.idRs1;
  assign busS.idRs2      = bus.idRs2;
  assign busS.idRd       = bus.idRd;
  assign busS.idRegWrite = bus.idRegWrite;
  assign busS.idMemRead  = bus.idMemRead;
  assign busS.exFlush    = bus.exFlush;
  assign busS.pipeHold   = bus.pipeHold;

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int rs1;
    int rs2;
    int rd;
    bit rw;
    bit ld;
  } instr_t;

  typedef struct {
    int v, rs1, rs2, rd, rw, ld, fl, hd;
    int f1, f2, st, bu, cnt;
  } vec_t;

  instr_t pipe [3];   // 0 = EX, 1 = MEM, 2 = WB
  int     mCnt  = 0;
  int     mCntS = 0;
  int     checks   = 0;
  int     failures = 0;
  vec_t   vecs [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int v, rs1, rs2, rd, rw, ld, fl, hd, f1, f2, st, bu, cnt);
    vec_t r;
    r = '{v, rs1, rs2, rd, rw, ld, fl, hd, f1, f2, st, bu, cnt};
    return r;
  endfunction

  // 0 = regfile, 1 = EX/MEM, 2 = MEM/WB: the youngest older instruction writing r wins.
  function automatic int producer(input int r);
    if (!pipe[0].valid) return 0;
    for (int k = 1; k <= 2; k++)
      if (pipe[k].valid && pipe[k].rw && pipe[k].rd == r && r != 0) return k;
    return 0;
  endfunction

  function automatic bit modelHazard();
    return pipe[0].valid && pipe[0].ld && pipe[0].rw && pipe[0].rd != 0 && bus.idValid &&
           (pipe[0].rd == int'(bus.idRs1) || pipe[0].rd == int'(bus.idRs2));
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
    mCnt  = 0;
    mCntS = 0;
  endtask

  task automatic drive(input int v, rs1, rs2, rd, rw, ld, fl, hd);
    bus.idValid    = v[0];
    bus.idRs1      = RW'(rs1);
    bus.idRs2      = RW'(rs2);
    bus.idRd       = RW'(rd);
    bus.idRegWrite = rw[0];
    bus.idMemRead  = ld[0];
    bus.exFlush    = fl[0];
    bus.pipeHold   = hd[0];
  endtask

  // Checks outputs against the model at the falling edge, then advances the model on the rising edge.
  task automatic step(input bit useVec, input int idx, input vec_t vx);
    bit h, st, bu;
    @(negedge clk);
    h  = modelHazard();
    st = h && !bus.exFlush;
    bu = h || bus.exFlush;
    chk("fwd1", int'(bus.forwardSelect1), producer(pipe[0].rs1));
    chk("fwd2", int'(bus.forwardSelect2), producer(pipe[0].rs2));
    chk("stall", int'(bus.stallDecode), int'(st));
    chk("bubble", int'(bus.bubbleExecute), int'(bu));
    chk("count", int'(bus.stallCount), mCnt);
    chk("countSmall", int'(busS.stallCount), mCntS);
    chk("stallSmall", int'(busS.stallDecode), int'(st));
    if (useVec) begin
      chk($sformatf("v%0d_fwd1", idx), int'(bus.forwardSelect1), vx.f1);
      chk($sformatf("v%0d_fwd2", idx), int'(bus.forwardSelect2), vx.f2);
      chk($sformatf("v%0d_stall", idx), int'(bus.stallDecode), vx.st);
      chk($sformatf("v%0d_bubble", idx), int'(bus.bubbleExecute), vx.bu);
      chk($sformatf("v%0d_count", idx), int'(bus.stallCount), vx.cnt);
    end
    @(posedge clk);
    if (rst_n && !bus.pipeHold) begin
      if (st) begin
        if (mCnt < (1 << CW) - 1) mCnt++;
        if (mCntS < (1 << SW) - 1) mCntS++;
      end
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (bu || !bus.idValid) begin
        pipe[0] = '{default: 0};
      end else begin
        pipe[0].valid = 1'b1;
        pipe[0].rs1   = int'(bus.idRs1);
        pipe[0].rs2   = int'(bus.idRs2);
        pipe[0].rd    = int'(bus.idRd);
        pipe[0].rw    = bus.idRegWrite;
        pipe[0].ld    = bus.idMemRead;
      end
    end
    #1;
  endtask

  task automatic plainStep();
    vec_t none;
    none = '{default: 0};
    step(1'b0, 0, none);
  endtask

  initial begin
    vec_t none;
    none = '{default: 0};
    modelReset();

    // Reset with arbitrary Decode inputs.
    drive(1, 3, 3, 3, 1, 1, 0, 0);
    #2;
    chk("rst_fwd1", int'(bus.forwardSelect1), 0);
    chk("rst_fwd2", int'(bus.forwardSelect2), 0);
    chk("rst_stall", int'(bus.stallDecode), 0);
    chk("rst_count", int'(bus.stallCount), 0);
    bus.exFlush = 1'b1;
    #1;
    chk("rst_bubble_flush", int'(bus.bubbleExecute), 1);
    chk("rst_stall_flush", int'(bus.stallDecode), 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, i, i + 1, i + 1, 1, 1, 0, 0);
      plainStep();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      plainStep();
    end

    // Directed sequences; expected values are per cycle, before the edge.
    //                v rs1 rs2 rd rw ld fl hd   f1 f2 st bu cnt
    vecs.push_back(mk(1, 1,  2,  5, 1, 0, 0, 0,  0, 0, 0, 0, 0)); // add x5,x1,x2
    vecs.push_back(mk(1, 5,  5,  6, 1, 0, 0, 0,  0, 0, 0, 0, 0)); // sub x6,x5,x5
    vecs.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0,  1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1,  2,  5, 1, 0, 0, 0,  0, 0, 0, 0, 0)); // add x5
    vecs.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0)); // nop
    vecs.push_back(mk(1, 5,  0,  7, 1, 0, 0, 0,  0, 0, 0, 0, 0)); // or x7,x5,x0
    vecs.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0,  2, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,  1,  5, 1, 0, 0, 0,  0, 0, 0, 0, 0)); // add x5
    vecs.push_back(mk(1, 2,  2,  5, 1, 0, 0, 0,  0, 0, 0, 0, 0)); // add x5
    vecs.push_back(mk(1, 5,  0,  7, 1, 0, 0, 0,  0, 0, 0, 0, 0)); // or x7,x5
    vecs.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4,  0,  8, 1, 1, 0, 0,  0, 0, 0, 0, 0)); // lw x8
    vecs.push_back(mk(1, 8,  3,  9, 1, 0, 0, 0,  0, 0, 1, 1, 0)); // add x9,x8,x3
    vecs.push_back(mk(1, 8,  3,  9, 1, 0, 0, 0,  0, 0, 0, 0, 1)); // held in ID
    vecs.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0,  2, 0, 0, 0, 1));
    vecs.push_back(mk(1, 4,  0,  0, 1, 1, 0, 0,  0, 0, 0, 0, 1)); // lw x0
    vecs.push_back(mk(1, 0,  0,  9, 1, 0, 0, 0,  0, 0, 0, 0, 1)); // add x9,x0
    vecs.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1,  1, 10, 1, 1, 0, 0,  0, 0, 0, 0, 1)); // lw x10
    vecs.push_back(mk(1,10, 10, 11, 1, 0, 1, 0,  0, 0, 0, 1, 1)); // consumer + flush
    vecs.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1,  1, 12, 1, 1, 0, 0,  0, 0, 0, 0, 1)); // lw x12
    vecs.push_back(mk(1,12,  0, 13, 1, 0, 0, 1,  0, 0, 1, 1, 1)); // hazard under hold
    vecs.push_back(mk(1,12,  0, 13, 1, 0, 0, 1,  0, 0, 1, 1, 1));
    vecs.push_back(mk(1,12,  0, 13, 1, 0, 0, 1,  0, 0, 1, 1, 1));
    vecs.push_back(mk(1,12,  0, 13, 1, 0, 0, 0,  0, 0, 1, 1, 1)); // hold released
    vecs.push_back(mk(1,12,  0, 13, 1, 0, 0, 0,  0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0,  0,  0, 0, 0, 0, 0,  2, 0, 0, 0, 2));
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
            vecs[i].rw, vecs[i].ld, vecs[i].fl, vecs[i].hd);
      step(1'b1, i, vecs[i]);
    end

    // Reset asserted in the middle of a stall cycle.
    drive(1, 1, 1, 14, 1, 1, 0, 0);
    plainStep();
    drive(1, 14, 2, 15, 1, 0, 0, 0);
    @(negedge clk);
    chk("midrst_pre_stall", int'(bus.stallDecode), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", int'(bus.stallDecode), 0);
    chk("midrst_bubble", int'(bus.bubbleExecute), 0);
    chk("midrst_count", int'(bus.stallCount), 0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    plainStep();

    // Randomized stream over a small register set to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(3) != 0) ? 1 : 0, $urandom_range(3), $urandom_range(3),
            $urandom_range(3), ($urandom_range(4) != 0) ? 1 : 0, $urandom_range(1),
            ($urandom_range(7) == 0) ? 1 : 0, ($urandom_range(5) == 0) ? 1 : 0);
      plainStep();
    end

    // Enough load-use pairs to pin the 4-bit counter at its ceiling.
    for (int i = 0; i < 20; i++) begin
      drive(1, 2, 2, 1, 1, 1, 0, 0);
      plainStep();
      drive(1, 1, 3, 4, 1, 0, 0, 0);
      plainStep();
      plainStep();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    plainStep();
    chk("sat_small", int'(busS.stallCount), (1 << SW) - 1);
    chk("sat_big", int'(bus.stallCount), mCnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
